// File: rtl/wb_write_port.sv
// rtl/wb_write_port.sv - writeback collector driving the single register file write port
//
// Purpose
//    Collects results from the ALU and the load unit through valid/ready
//    handshakes and queues them in a small FIFO. One result per cycle
//    retires onto W_ADDR/W_DATA/W_ENABLE. A per-register pending counter
//    lets issue logic stall on read-after-write hazards.
//
// Configuration
//    WB_RR_ARB_EN  defined   : round-robin arbitration between load and ALU
//                  undefined : fixed priority, load wins over ALU
//
// Parameters
//    DEPTH  FIFO entries, power of two, 2..16
//    CNT_W  width of each per-register pending counter
//
// Ports
//    clk          clock, all state updates on posedge
//    rst          synchronous reset, active-low
//    ALU_VALID    ALU result valid
//    ALU_ADDR     ALU destination register
//    ALU_DATA     ALU result
//    ALU_READY    ALU result accepted this cycle (combinational)
//    LD_VALID     load result valid
//    LD_ADDR      load destination register
//    LD_DATA      load data
//    LD_READY     load result accepted this cycle (combinational)
//    ISSUE_VALID  instruction with a destination issued this cycle
//    ISSUE_ADDR   destination of the issued instruction
//    ISSUE_READY  pending counter for ISSUE_ADDR not saturated (combinational)
//    PEND_MASK    bit i set while pending counter i is nonzero (registered)
//    W_ADDR       register file write address (registered)
//    W_DATA       register file write data (registered)
//    W_ENABLE     register file write strobe (registered)
//    BUSY         FIFO non-empty or W_ENABLE high (combinational)

module wb_write_port #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ALU_VALID,
   input  logic [2:0] ALU_ADDR,
   input  logic [7:0] ALU_DATA,
   output logic       ALU_READY,
   input  logic       LD_VALID,
   input  logic [2:0] LD_ADDR,
   input  logic [7:0] LD_DATA,
   output logic       LD_READY,
   input  logic       ISSUE_VALID,
   input  logic [2:0] ISSUE_ADDR,
   output logic       ISSUE_READY,
   output logic [7:0] PEND_MASK,
   output logic [2:0] W_ADDR,
   output logic [7:0] W_DATA,
   output logic       W_ENABLE,
   output logic       BUSY
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FULL_N  = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // FIFO storage: entry = {addr[2:0], data[7:0]}
   logic [10:0]      fifo_mem [DEPTH];
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   count;
   logic [10:0]      head;
   logic [10:0]      push_entry;
   logic             full;
   logic             push;
   logic             pop;
   logic             ld_fire;
   logic             alu_fire;

   // Pending scoreboard
   logic [CNT_W-1:0] cnt_q [8];
   logic [CNT_W-1:0] cnt_d [8];
   logic [7:0]       inc_vec;
   logic [7:0]       dec_vec;
   logic             issue_fire;

   // Acceptance looks at the registered count only, so a full FIFO refuses
   // new results even in a cycle where it is also retiring one.
   assign full = (count == FULL_N);

`ifdef WB_RR_ARB_EN
   // last_alu = 0 means the load unit was granted most recently (reset value).
   logic last_alu;

   // A producer is refused only when both request and it is the other's turn.
   assign LD_READY  = rst && !full && !(LD_VALID && ALU_VALID && !last_alu);
   assign ALU_READY = rst && !full && !(LD_VALID && ALU_VALID &&  last_alu);

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_alu <= 1'b0;
      end else if (ld_fire) begin
         last_alu <= 1'b0;
      end else if (alu_fire) begin
         last_alu <= 1'b1;
      end
   end
`else
   assign LD_READY  = rst && !full;
   assign ALU_READY = rst && !full && !LD_VALID;
`endif

   assign ld_fire    = LD_VALID && LD_READY;
   assign alu_fire   = ALU_VALID && ALU_READY && !ld_fire;
   assign push       = ld_fire || alu_fire;
   assign push_entry = ld_fire ? {LD_ADDR, LD_DATA} : {ALU_ADDR, ALU_DATA};

   // Drain runs every cycle the FIFO holds something; the entry accepted at
   // an edge is therefore presented one edge later at the earliest.
   assign pop  = rst && (count != '0);
   assign head = fifo_mem[rd_ptr[PTR_W-1:0]];

   // Storage carries no reset: entries are discarded by clearing the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         W_ENABLE <= 1'b0;
         W_ADDR   <= 3'd0;
         W_DATA   <= 8'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            W_ADDR <= head[10:8];
            W_DATA <= head[7:0];
         end
         W_ENABLE <= pop;
         count    <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   assign BUSY = (count != '0) || W_ENABLE;

   // Issue is only accepted while the destination counter has headroom.
   assign ISSUE_READY = rst && (cnt_q[ISSUE_ADDR] != CNT_MAX);
   assign issue_fire  = ISSUE_VALID && ISSUE_READY;

   assign inc_vec = issue_fire ? (8'b1 << ISSUE_ADDR) : 8'b0;
   assign dec_vec = W_ENABLE   ? (8'b1 << W_ADDR)     : 8'b0;

   // A matching issue and retirement cancel out. A lone retirement against
   // an idle counter is an issuer protocol error and the counter holds at 0.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_vec[i] && !dec_vec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
         PEND_MASK <= 8'd0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            cnt_q[i]     <= cnt_d[i];
            PEND_MASK[i] <= |cnt_d[i];
         end
      end
   end

endmodule
